// File: rtl/instr_fetch_unit_pkg.sv
// Shared RISC-V constants and fetch-path types used by the fetch unit and decoders.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  // One prefetch buffer entry: the PC travels with its instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetchEntry_t;

  function automatic logic [XLEN-1:0] nextPc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, branch resolution and decode.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, instr_pc_plus4,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, instr_pc_plus4,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head word is readable combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  // Pop only when non-empty; push into a full FIFO only alongside a pop (slot freed same edge).
  always_comb begin
    doPop  = pop && (count != '0);
    doPush = push && ((count != CNT_W'(DEPTH)) || doPop);
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // Storage write; when full with push+pop the overwritten slot is the one being popped.
  always_ff @(posedge clk) begin
    if (doPush && !(rst || flush)) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, prefetch buffer,
// redirect flush with drop-counting of in-flight responses.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] rspPc;
  logic [XLEN-1:0] lastPc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] dropCnt;
  logic [CNT_W-1:0] fifoCount;
  logic             creditOk;
  logic             reqValid;
  logic             reqFire;
  logic             rspFire;
  logic             pushEn;
  logic             popEn;
  logic             instrValid;
  fetchEntry_t      headEntry;
  fetchEntry_t      pushEntry;

  // Request credit, handshake qualifiers and FIFO push/pop decisions.
  always_comb begin
    creditOk   = ({1'b0, fifoCount} + {1'b0, outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);
    reqValid   = !rst && !bus.redirect_valid && creditOk;
    reqFire    = reqValid && bus.imem_req_ready;
    rspFire    = bus.imem_rsp_valid && (outstanding != '0);
    pushEn     = rspFire && (dropCnt == '0) && !bus.redirect_valid;
    instrValid = !rst && (fifoCount != '0);
    popEn      = instrValid && bus.instr_ready && !bus.redirect_valid;
    pushEntry  = '{pc: rspPc, instr: bus.imem_rsp_data};
  end

  // Decode-facing outputs: FIFO head when valid, otherwise NOP with the last delivered PC.
  always_comb begin
    bus.imem_req_valid = reqValid;
    bus.imem_req_addr  = fetchPc;
    bus.instr_valid    = instrValid;
    if (instrValid) begin
      bus.instr    = headEntry.instr;
      bus.instr_pc = headEntry.pc;
    end else if (rst) begin
      bus.instr    = NOP_INSTR;
      bus.instr_pc = RESET_PC;
    end else begin
      bus.instr    = NOP_INSTR;
      bus.instr_pc = lastPc;
    end
    bus.instr_pc_plus4 = nextPc(bus.instr_pc);
  end

  // PC registers and request/drop counters. A redirect re-arms dropCnt with every request
  // still in flight after this cycle, so a response arriving in the redirect cycle counts
  // as already consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      lastPc      <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(reqFire) - CNT_W'(rspFire);
      if (popEn) lastPc <= headEntry.pc;
      if (bus.redirect_valid) begin
        fetchPc <= alignPc(bus.redirect_pc);
        rspPc   <= alignPc(bus.redirect_pc);
        dropCnt <= outstanding - CNT_W'(rspFire);
      end else begin
        if (reqFire) fetchPc <= nextPc(fetchPc);
        if (rspFire) begin
          if (dropCnt != '0) dropCnt <= dropCnt - CNT_W'(1);
          else               rspPc   <= nextPc(rspPc);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect_valid),
    .push     (pushEn),
    .pushData (pushEntry),
    .pop      (popEn),
    .headData (headEntry),
    .count    (fifoCount)
  );

  aRspWithoutRequest: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && (outstanding == '0)));
  aDropBound: assert property (@(posedge clk) disable iff (rst)
    dropCnt <= outstanding);
  aCreditBound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, fifoCount} + {1'b0, outstanding}) <= (CNT_W + 1)'(FIFO_DEPTH));

endmodule
